// File: rtl/multi_mode_timer_pkg.sv
// Shared types and helpers for the multi-mode timer.
// States, count direction encoding and preset clamping.
package multi_mode_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Out-of-range preset fields saturate at modulus-1.
  function automatic int unsigned clamp(
    input int unsigned v,
    input int unsigned m
  );
    return (v >= m) ? m - 1 : v;
  endfunction

endpackage

// File: rtl/multi_mode_timer_tick_gen.sv
// One-cycle tick enable every N clocks while enabled.
// Phase is kept while disabled so a pause loses no fraction.
module tick_gen #(
  parameter int N = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  // Prescaler: 0..N-1 while enabled, frozen otherwise.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/multi_mode_timer.sv
// Up/down h:m:s timer with lap capture, pause and expiry.
// Time advances on a clock-enable tick; single clock domain.
module multi_mode_timer
  import multi_mode_timer_pkg::*;
#(
  parameter int HOUR   = 24,
  parameter int MINUTE = 60,
  parameter int SECOND = 60,
  parameter int N      = 25_000_000,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         start_stop,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] preset_hour,
  input  logic [W-1:0] preset_minute,
  input  logic [W-1:0] preset_second,
  input  logic         lap,
  output logic [W-1:0] cur_hour,
  output logic [W-1:0] cur_minute,
  output logic [W-1:0] cur_second,
  output logic [W-1:0] lap_hour,
  output logic [W-1:0] lap_minute,
  output logic [W-1:0] lap_second,
  output logic         lap_valid,
  output logic         running,
  output logic         wrap,
  output logic         expired
);

  localparam logic [W-1:0] H_MAX = W'(HOUR - 1);
  localparam logic [W-1:0] M_MAX = W'(MINUTE - 1);
  localparam logic [W-1:0] S_MAX = W'(SECOND - 1);

  state_t       state;
  logic         mode_q;
  logic         tick;
  logic         run_en;
  logic         pre_clr;
  logic         start_ok;
  logic         ld_ok;
  logic         at_zero;
  logic         at_max;
  logic         expire_now;
  logic [W-1:0] up_h, up_m, up_s;
  logic [W-1:0] dn_h, dn_m, dn_s;

  assign run_en  = (state == RUN);
  assign running = run_en;
  assign expired = (state == EXPIRED);

  assign at_zero = (cur_hour == '0) &&
                   (cur_minute == '0) &&
                   (cur_second == '0);
  assign at_max  = (cur_hour == H_MAX) &&
                   (cur_minute == M_MAX) &&
                   (cur_second == S_MAX);

  // A down-count start from 0:0:0 would expire at once; refuse it.
  assign start_ok = start_stop &&
                    !(mode == MODE_DOWN && at_zero);
  assign ld_ok    = load && (state != RUN);
  assign pre_clr  = clear || ld_ok ||
                    (state == IDLE && start_ok);

  assign expire_now = tick && (mode_q == MODE_DOWN) && at_zero;

  tick_gen #(
    .N(N)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .clr (pre_clr),
    .tick(tick)
  );

  // Next count for one step in each direction, with carry/borrow.
  always_comb begin
    up_h = cur_hour;
    up_m = cur_minute;
    up_s = cur_second + W'(1);
    if (cur_second == S_MAX) begin
      up_s = '0;
      up_m = cur_minute + W'(1);
      if (cur_minute == M_MAX) begin
        up_m = '0;
        up_h = (cur_hour == H_MAX) ? '0 : cur_hour + W'(1);
      end
    end
    dn_h = cur_hour;
    dn_m = cur_minute;
    dn_s = cur_second - W'(1);
    if (cur_second == '0) begin
      dn_s = S_MAX;
      dn_m = cur_minute - W'(1);
      if (cur_minute == '0) begin
        dn_m = M_MAX;
        dn_h = cur_hour - W'(1);
      end
    end
  end

  // Control FSM, count and lap registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= MODE_UP;
      cur_hour   <= '0;
      cur_minute <= '0;
      cur_second <= '0;
      lap_hour   <= '0;
      lap_minute <= '0;
      lap_second <= '0;
      lap_valid  <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      lap_valid <= 1'b0;
      wrap      <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        cur_hour   <= '0;
        cur_minute <= '0;
        cur_second <= '0;
      end else if (ld_ok) begin
        state      <= IDLE;
        cur_hour   <= W'(clamp(32'(preset_hour), HOUR));
        cur_minute <= W'(clamp(32'(preset_minute), MINUTE));
        cur_second <= W'(clamp(32'(preset_second), SECOND));
      end else begin
        unique case (state)
          IDLE: begin
            if (start_ok) begin
              state  <= RUN;
              mode_q <= mode;
            end
          end
          RUN: begin
            if (tick && mode_q == MODE_UP) begin
              cur_hour   <= up_h;
              cur_minute <= up_m;
              cur_second <= up_s;
              wrap       <= at_max;
            end else if (tick && !at_zero) begin
              cur_hour   <= dn_h;
              cur_minute <= dn_m;
              cur_second <= dn_s;
            end
            if (expire_now) begin
              state <= EXPIRED;
            end else if (start_stop) begin
              state <= PAUSE;
            end
            if (!start_stop && lap) begin
              lap_hour   <= cur_hour;
              lap_minute <= cur_minute;
              lap_second <= cur_second;
              lap_valid  <= 1'b1;
            end
          end
          PAUSE: begin
            if (start_stop) begin
              state  <= RUN;
              mode_q <= mode;
            end else if (lap) begin
              lap_hour   <= cur_hour;
              lap_minute <= cur_minute;
              lap_second <= cur_second;
              lap_valid  <= 1'b1;
            end
          end
          EXPIRED: begin
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_mode_timer.sv
// Self-checking bench for multi_mode_timer.
// Table vectors, directed sequences and a random run vs a model.
module tb_multi_mode_timer;

  localparam int HR = 2;
  localparam int MN = 3;
  localparam int SC = 5;
  localparam int NN = 4;
  localparam int TOT = HR * MN * SC;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_EXP   = 3;

  logic       clk;
  logic       rst;
  logic       mode;
  logic       start_stop;
  logic       clear;
  logic       load;
  logic [7:0] preset_hour;
  logic [7:0] preset_minute;
  logic [7:0] preset_second;
  logic       lap;
  logic [7:0] cur_hour, cur_minute, cur_second;
  logic [7:0] lap_hour, lap_minute, lap_second;
  logic       lap_valid, running, wrap, expired;

  multi_mode_timer #(
    .HOUR(HR), .MINUTE(MN), .SECOND(SC),
    .N(NN), .W(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .start_stop   (start_stop),
    .clear        (clear),
    .load         (load),
    .preset_hour  (preset_hour),
    .preset_minute(preset_minute),
    .preset_second(preset_second),
    .lap          (lap),
    .cur_hour     (cur_hour),
    .cur_minute   (cur_minute),
    .cur_second   (cur_second),
    .lap_hour     (lap_hour),
    .lap_minute   (lap_minute),
    .lap_second   (lap_second),
    .lap_valid    (lap_valid),
    .running      (running),
    .wrap         (wrap),
    .expired      (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: count held as total seconds since 0:0:0.
  int m_t = 0;
  int m_st = ST_IDLE;
  int m_ph = 0;
  int m_lap = 0;
  bit m_md = 1'b0;
  bit m_wrap = 1'b0;
  bit m_lv = 1'b0;

  typedef struct {
    bit r, md, ss, cl, ld;
    int ph, pm, ps;
    int eh, em, es;
    bit erun, eexp;
  } vec_t;

  vec_t tbl[$];

  function automatic void chk(string nm,
                              logic [31:0] got,
                              logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  function automatic int cmin(int v, int m);
    return (v >= m) ? m - 1 : v;
  endfunction

  function automatic logic [31:0] hms(int t);
    return {8'd0, 8'(t / (MN * SC)),
            8'((t / SC) % MN), 8'(t % SC)};
  endfunction

  function automatic logic [31:0] cur_v();
    return {8'd0, cur_hour, cur_minute, cur_second};
  endfunction

  function automatic logic [31:0] lap_v();
    return {8'd0, lap_hour, lap_minute, lap_second};
  endfunction

  function automatic void model(bit r, bit md, bit ss,
                                bit cl, bit ld, bit lp,
                                int ph, int pm, int ps);
    bit tk;
    bit fin;
    int prev;
    m_wrap = 1'b0;
    m_lv = 1'b0;
    if (r) begin
      m_t = 0; m_st = ST_IDLE; m_md = 1'b0;
      m_ph = 0; m_lap = 0;
      return;
    end
    tk = (m_st == ST_RUN) && (m_ph == NN - 1);
    if (cl) begin
      m_st = ST_IDLE; m_t = 0; m_ph = 0;
    end else if (ld && m_st != ST_RUN) begin
      m_st = ST_IDLE; m_ph = 0;
      m_t = cmin(ph, HR) * MN * SC +
            cmin(pm, MN) * SC + cmin(ps, SC);
    end else if (m_st == ST_IDLE) begin
      if (ss && !(md && m_t == 0)) begin
        m_st = ST_RUN; m_md = md; m_ph = 0;
      end
    end else if (m_st == ST_RUN) begin
      prev = m_t;
      fin = 1'b0;
      m_ph = (m_ph + 1) % NN;
      if (tk) begin
        if (!m_md) begin
          m_t = (m_t + 1) % TOT;
          m_wrap = (m_t == 0);
        end else if (m_t == 0) begin
          fin = 1'b1;
        end else begin
          m_t = m_t - 1;
        end
      end
      if (fin) m_st = ST_EXP;
      else if (ss) m_st = ST_PAUSE;
      if (!ss && lp) begin
        m_lap = prev; m_lv = 1'b1;
      end
    end else if (m_st == ST_PAUSE) begin
      if (ss) begin
        m_st = ST_RUN; m_md = md;
      end else if (lp) begin
        m_lap = m_t; m_lv = 1'b1;
      end
    end
  endfunction

  function automatic void scoreboard();
    chk("sb_cur", cur_v(), hms(m_t));
    chk("sb_lap", lap_v(), hms(m_lap));
    chk("sb_flags",
        32'({lap_valid, running, wrap, expired}),
        32'({m_lv, m_st == ST_RUN, m_wrap, m_st == ST_EXP}));
  endfunction

  task automatic step(input bit r, input bit md,
                      input bit ss, input bit cl,
                      input bit ld, input bit lp,
                      input int ph, input int pm,
                      input int ps);
    rst = r; mode = md; start_stop = ss;
    clear = cl; load = ld; lap = lp;
    preset_hour = 8'(ph);
    preset_minute = 8'(pm);
    preset_second = 8'(ps);
    @(posedge clk);
    model(r, md, ss, cl, ld, lp, ph, pm, ps);
    #1;
    scoreboard();
    rst = 1'b0; start_stop = 1'b0; clear = 1'b0;
    load = 1'b0; lap = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, mode, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic add(input bit r, input bit md,
                     input bit ss, input bit cl,
                     input bit ld, input int ph,
                     input int pm, input int ps,
                     input int eh, input int em,
                     input int es, input bit erun,
                     input bit eexp);
    vec_t v;
    v.r = r; v.md = md; v.ss = ss; v.cl = cl; v.ld = ld;
    v.ph = ph; v.pm = pm; v.ps = ps;
    v.eh = eh; v.em = em; v.es = es;
    v.erun = erun; v.eexp = eexp;
    tbl.push_back(v);
  endtask

  int wraps;
  int wrap_at;
  bit run_all;
  int pulses;

  initial begin
    rst = 1'b1; mode = 1'b0; start_stop = 1'b0;
    clear = 1'b0; load = 1'b0; lap = 1'b0;
    preset_hour = '0; preset_minute = '0;
    preset_second = '0;

    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 9, 9, 1, 2, 4, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1, 0, 1, 1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 3, 0, 0, 3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 3, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 1, 0, 0, 3, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 1, 0, 0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 0, 1, 0, 0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].md, tbl[i].ss, tbl[i].cl,
           tbl[i].ld, 1'b0, tbl[i].ph, tbl[i].pm,
           tbl[i].ps);
      chk($sformatf("tbl%0d_cur", i), cur_v(),
          {8'd0, 8'(tbl[i].eh), 8'(tbl[i].em),
           8'(tbl[i].es)});
      chk($sformatf("tbl%0d_flags", i),
          32'({running, expired}),
          32'({tbl[i].erun, tbl[i].eexp}));
    end

    // Up count through a full wrap.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    wraps = 0; wrap_at = 0; run_all = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      idle(1);
      if (wrap) begin wraps++; wrap_at = i; end
      if (!running) run_all = 1'b0;
      if (i == 116) chk("t1_max", cur_v(), 32'h00010204);
    end
    chk("t1_wraps", 32'(wraps), 32'd1);
    chk("t1_wrap_at", 32'(wrap_at), 32'd120);
    chk("t1_running", 32'(run_all), 32'd1);
    chk("t1_zero", cur_v(), 32'h0);

    // Pause two clocks into a second, hold, resume.
    idle(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("t2_paused", 32'(running), 32'd0);
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (i % 10 == 9) chk("t2_hold", cur_v(), 32'h0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(1);
    chk("t2_res1", cur_v(), 32'h0);
    idle(1);
    chk("t2_res2", cur_v(), 32'h00000001);

    // Countdown to expiry.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      idle(4);
      chk($sformatf("t3_dn%0d", k), cur_v(), hms(6 - k));
      chk($sformatf("t3_run%0d", k), 32'(running), 32'd1);
    end
    idle(4);
    chk("t3_exp", 32'({running, expired}), 32'b01);
    chk("t3_exp_cur", cur_v(), 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("t3_ss_ign", 32'({running, expired}), 32'b01);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    chk("t3_lap_ign", 32'(lap_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    chk("t3_clear", 32'({running, expired}), 32'b00);

    // Lap on the tick edge 0:0:2 -> 0:0:3.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(8);
    chk("t5_pre", cur_v(), 32'h00000002);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    chk("t5_cur", cur_v(), 32'h00000003);
    chk("t5_lap", lap_v(), 32'h00000002);
    pulses = 32'(lap_valid);
    idle(1);
    pulses += 32'(lap_valid);
    chk("t5_pulses", 32'(pulses), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    chk("t5_idle_lap", 32'(lap_valid), 32'd0);
    chk("t5_lap_kept", lap_v(), 32'h00000002);

    // Reset mid-run clears everything.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    chk("t6_cur", cur_v(), 32'h0);
    chk("t6_lap", lap_v(), 32'h0);
    chk("t6_flags",
        32'({lap_valid, running, wrap, expired}), 32'h0);

    // Random stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit r, md, ss, cl, ld, lp;
      int ph, pm, ps;
      r  = ($urandom_range(0, 299) == 0);
      md = 1'($urandom_range(0, 1));
      ss = ($urandom_range(0, 11) == 0);
      cl = ($urandom_range(0, 59) == 0);
      ld = ($urandom_range(0, 24) == 0);
      lp = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        ph = int'($urandom_range(0, 255));
        pm = int'($urandom_range(0, 255));
        ps = int'($urandom_range(0, 255));
      end else begin
        ph = int'($urandom_range(0, 2));
        pm = int'($urandom_range(0, 3));
        ps = int'($urandom_range(0, 5));
      end
      step(r, md, ss, cl, ld, lp, ph, pm, ps);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
